// File: rtl/upstream_sched_pkg.sv
// rtl/upstream_sched_pkg.sv - shared types and constants for the upstream channel scheduler
package upstream_sched_pkg;

  localparam int ADDR_W        = 32;
  localparam int LEN_W         = 16;
  localparam int TAG_W         = 4;
  localparam int FRAG_LOG2_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_NEXT      = 3'd5
  } sched_state_t;

  // Smaller of two byte counts; used to clip a fragment to the boundary room.
  function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/upstream_rr_pick.sv
// rtl/upstream_rr_pick.sv - combinational round-robin picker over NREQ request lines
module upstream_rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any
);

  // Scan from the farthest slot back to the pointer so the nearest valid slot wins last.
  always_comb begin
    int w_idx;
    w_idx   = 0;
    o_grant = '0;
    o_any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % NREQ;
      if (i_req[w_idx]) begin
        o_grant = IDX_W'(w_idx);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/upstream_channel_sched.sv
// rtl/upstream_channel_sched.sv - round-robin DMA scheduler splitting transfers at destination boundaries
module upstream_channel_sched
  import upstream_sched_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int FRAG_LOG2 = FRAG_LOG2_DEF,
  localparam int IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*ADDR_W-1:0]  i_req_saddr,
  input  logic [NREQ*ADDR_W-1:0]  i_req_daddr,
  input  logic [NREQ*LEN_W-1:0]   i_req_length,
  input  logic [NREQ*TAG_W-1:0]   i_req_tag,
  output logic [NREQ-1:0]         o_req_ack,
  output logic [NREQ-1:0]         o_req_done,
  output logic                    o_channel_sel,
  output logic                    o_channel_req,
  output logic [ADDR_W-1:0]       o_channel_saddr,
  output logic [ADDR_W-1:0]       o_channel_daddr,
  output logic [LEN_W-1:0]        o_channel_length,
  output logic [TAG_W-1:0]        o_channel_tag,
  input  logic                    i_channel_busy,
  output logic                    o_sched_busy
);

  localparam logic [NREQ-1:0]    ONE_HOT0 = NREQ'(1);
  localparam logic [FRAG_LOG2:0] FRAG_MAX = {1'b1, {FRAG_LOG2{1'b0}}};

  sched_state_t      r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_grant;
  logic [ADDR_W-1:0] r_cur_saddr;
  logic [ADDR_W-1:0] r_cur_daddr;
  logic [LEN_W-1:0]  r_cur_rem;
  logic [TAG_W-1:0]  r_cur_tag;
  logic              r_zero_pend;
  logic [NREQ-1:0]   r_req_ack;
  logic [NREQ-1:0]   r_req_done;
  logic              r_chan_req;
  logic [ADDR_W-1:0] r_chan_saddr;
  logic [ADDR_W-1:0] r_chan_daddr;
  logic [LEN_W-1:0]  r_chan_len;
  logic [TAG_W-1:0]  r_chan_tag;
  logic              r_sched_busy;

  logic [IDX_W-1:0]  w_grant;
  logic              w_any;
  logic [ADDR_W-1:0] w_sel_saddr;
  logic [ADDR_W-1:0] w_sel_daddr;
  logic [LEN_W-1:0]  w_sel_len;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [FRAG_LOG2:0] w_room;
  logic [LEN_W-1:0]  w_room_ext;
  logic [LEN_W-1:0]  w_frag;

  upstream_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_sel_saddr = i_req_saddr[w_grant*ADDR_W +: ADDR_W];
  assign w_sel_daddr = i_req_daddr[w_grant*ADDR_W +: ADDR_W];
  assign w_sel_len   = i_req_length[w_grant*LEN_W +: LEN_W];
  assign w_sel_tag   = i_req_tag[w_grant*TAG_W +: TAG_W];

  // Bytes left before the next destination boundary; a full window when aligned.
  assign w_room     = FRAG_MAX - {1'b0, r_cur_daddr[FRAG_LOG2-1:0]};
  assign w_room_ext = {{(LEN_W-FRAG_LOG2-1){1'b0}}, w_room};
  assign w_frag     = min_len(r_cur_rem, w_room_ext);

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Scheduler FSM: arbitration, fragment issue, engine handshake and completion reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_grant      <= '0;
      r_cur_saddr  <= '0;
      r_cur_daddr  <= '0;
      r_cur_rem    <= '0;
      r_cur_tag    <= '0;
      r_zero_pend  <= 1'b0;
      r_req_ack    <= '0;
      r_req_done   <= '0;
      r_chan_req   <= 1'b0;
      r_chan_saddr <= '0;
      r_chan_daddr <= '0;
      r_chan_len   <= '0;
      r_chan_tag   <= '0;
      r_sched_busy <= 1'b0;
    end else begin
      r_req_ack  <= '0;
      r_req_done <= '0;
      r_chan_req <= 1'b0;
      // A zero-length descriptor completes the cycle after its acknowledge.
      if (r_zero_pend) begin
        r_req_done  <= ONE_HOT0 << r_grant;
        r_zero_pend <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (|i_req_valid) begin
            r_state      <= S_ARB;
            r_sched_busy <= 1'b1;
          end
        end
        S_ARB: begin
          if (w_any) begin
            r_grant     <= w_grant;
            r_cur_saddr <= w_sel_saddr;
            r_cur_daddr <= w_sel_daddr;
            r_cur_rem   <= w_sel_len;
            r_cur_tag   <= w_sel_tag;
            r_req_ack   <= ONE_HOT0 << w_grant;
            if (w_sel_len == '0) begin
              r_zero_pend  <= 1'b1;
              r_ptr        <= idx_inc(w_grant);
              r_state      <= S_IDLE;
              r_sched_busy <= 1'b0;
            end else begin
              r_state <= S_NEXT;
            end
          end else begin
            // Requester withdrew between idle detection and arbitration.
            r_state      <= S_IDLE;
            r_sched_busy <= 1'b0;
          end
        end
        S_NEXT: begin
          r_chan_saddr <= r_cur_saddr;
          r_chan_daddr <= r_cur_daddr;
          r_chan_len   <= w_frag;
          r_chan_tag   <= r_cur_tag;
          r_state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!i_channel_busy) begin
            r_chan_req  <= 1'b1;
            r_cur_saddr <= r_cur_saddr + {{(ADDR_W-LEN_W){1'b0}}, r_chan_len};
            r_cur_daddr <= r_cur_daddr + {{(ADDR_W-LEN_W){1'b0}}, r_chan_len};
            r_cur_rem   <= r_cur_rem - r_chan_len;
            r_state     <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i_channel_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!i_channel_busy) begin
            if (r_cur_rem != '0) begin
              r_state <= S_NEXT;
            end else begin
              r_req_done   <= ONE_HOT0 << r_grant;
              r_ptr        <= idx_inc(r_grant);
              r_state      <= S_IDLE;
              r_sched_busy <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_sched_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ack        = r_req_ack;
  assign o_req_done       = r_req_done;
  assign o_channel_sel    = r_chan_req;
  assign o_channel_req    = r_chan_req;
  assign o_channel_saddr  = r_chan_saddr;
  assign o_channel_daddr  = r_chan_daddr;
  assign o_channel_length = r_chan_len;
  assign o_channel_tag    = r_chan_tag;
  assign o_sched_busy     = r_sched_busy;

endmodule

// File: tb/tb_upstream_channel_sched.sv
// tb/tb_upstream_channel_sched.sv - self-checking bench for the upstream channel scheduler
module tb_upstream_channel_sched;

  localparam int NREQ = 4;
  localparam int FRAG = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    pend = '0;
  logic [NREQ-1:0]    ackd = '0;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_saddr = '0;
  logic [NREQ*32-1:0] req_daddr = '0;
  logic [NREQ*16-1:0] req_length = '0;
  logic [NREQ*4-1:0]  req_tag = '0;
  logic [NREQ-1:0]    req_ack, req_done;
  logic               ch_sel, ch_req, sched_busy;
  logic [31:0]        ch_saddr, ch_daddr;
  logic [15:0]        ch_len;
  logic [3:0]         ch_tag;
  logic               eng_busy = 1'b0;
  logic               force_busy = 1'b0;
  logic               chan_busy;

  assign req_valid = pend & ~ackd;
  assign chan_busy = eng_busy | force_busy;

  upstream_channel_sched #(.NREQ(NREQ), .FRAG_LOG2(7)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (req_valid),
    .i_req_saddr      (req_saddr),
    .i_req_daddr      (req_daddr),
    .i_req_length     (req_length),
    .i_req_tag        (req_tag),
    .o_req_ack        (req_ack),
    .o_req_done       (req_done),
    .o_channel_sel    (ch_sel),
    .o_channel_req    (ch_req),
    .o_channel_saddr  (ch_saddr),
    .o_channel_daddr  (ch_daddr),
    .o_channel_length (ch_len),
    .o_channel_tag    (ch_tag),
    .i_channel_busy   (chan_busy),
    .o_sched_busy     (sched_busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int batch_id = 0;
  int seen_id = 0;
  int ptr_model = 0;
  int t_start = 0;
  int fall_c = -1;
  int sel_err = 0;
  int pulse_err = 0;
  int both_err = 0;
  logic prev_busy = 1'b0;
  logic prev_req = 1'b0;
  int ack_q[$];
  int ack_c[$];
  int done_q[$];
  int done_c[$];
  logic [83:0] frag_q[$];
  logic [31:0] d_s[NREQ];
  logic [31:0] d_d[NREQ];
  logic [15:0] d_l[NREQ];
  logic [3:0]  d_t[NREQ];

  // Observer: logs acks, completions and issued fragments; requesters withdraw once acked.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (batch_id != seen_id) begin
        ackd = '0;
        seen_id = batch_id;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] === 1'b1) begin
          ack_q.push_back(i);
          ack_c.push_back(cyc);
          ackd[i] = 1'b1;
        end
        if (req_done[i] === 1'b1) begin
          done_q.push_back(i);
          done_c.push_back(cyc);
        end
        if (req_ack[i] === 1'b1 && req_done[i] === 1'b1) both_err++;
      end
      if (ch_sel !== ch_req) sel_err++;
      if (ch_req === 1'b1 && prev_req === 1'b1) pulse_err++;
      if (ch_req === 1'b1) frag_q.push_back({ch_saddr, ch_daddr, ch_len, ch_tag});
      if (prev_busy && !chan_busy) fall_c = cyc;
      prev_busy = chan_busy;
      prev_req = ch_req;
    end
  end

  // Engine model: goes busy a few cycles after each request, then idles again.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ch_req === 1'b1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        eng_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        eng_busy = 1'b0;
      end
    end
  end

  task automatic start_batch(input logic [NREQ-1:0] mask);
    pend = '0;
    ack_q.delete(); ack_c.delete(); done_q.delete(); done_c.delete(); frag_q.delete();
    fall_c = -1;
    batch_id++;
    @(posedge clk);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      req_saddr[i*32 +: 32] = d_s[i];
      req_daddr[i*32 +: 32] = d_d[i];
      req_length[i*16 +: 16] = d_l[i];
      req_tag[i*4 +: 4] = d_t[i];
    end
    pend = mask;
    t_start = cyc;
  endtask

  task automatic finish_batch(input logic [NREQ-1:0] mask, input string name);
    int n, idx, got;
    int order[$];
    logic [83:0] exp_f[$];
    logic [31:0] s, d;
    logic [15:0] rem, room, f;
    n = $countones(mask);
    for (int w = 0; w < 5000 && done_q.size() < n; w++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (done_q.size() != n) begin
      bad++;
      $display("FAIL %s_done_count: got %0d want %0d", name, done_q.size(), n);
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr_model + k) % NREQ;
      if (mask[idx]) order.push_back(idx);
    end
    for (int j = 0; j < n; j++) begin
      got = (j < ack_q.size()) ? ack_q[j] : -1;
      total++;
      if (got != order[j]) begin
        bad++;
        $display("FAIL %s_ack_order[%0d]: got %0d want %0d", name, j, got, order[j]);
      end
      got = (j < done_q.size()) ? done_q[j] : -1;
      total++;
      if (got != order[j]) begin
        bad++;
        $display("FAIL %s_done_order[%0d]: got %0d want %0d", name, j, got, order[j]);
      end
    end
    foreach (order[j]) begin
      s = d_s[order[j]];
      d = d_d[order[j]];
      rem = d_l[order[j]];
      while (rem != 0) begin
        room = 16'(FRAG - (d % FRAG));
        f = (rem < room) ? rem : room;
        exp_f.push_back({s, d, f, d_t[order[j]]});
        s = s + 32'(f);
        d = d + 32'(f);
        rem = rem - f;
      end
    end
    total++;
    if (frag_q.size() != exp_f.size()) begin
      bad++;
      $display("FAIL %s_frag_count: got %0d want %0d", name, frag_q.size(), exp_f.size());
    end
    for (int j = 0; j < exp_f.size() && j < frag_q.size(); j++) begin
      total++;
      if (frag_q[j] !== exp_f[j]) begin
        bad++;
        $display("FAIL %s_frag[%0d]: got %h want %h", name, j, frag_q[j], exp_f[j]);
      end
    end
    total++;
    if (sched_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_after: got %b want 0", name, sched_busy);
    end
    if (n > 0) ptr_model = (order[n-1] + 1) % NREQ;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({req_ack, req_done} !== '0) begin
      bad++;
      $display("FAIL reset_ack_done: got %h want 0", {req_ack, req_done});
    end
    total++;
    if ({ch_sel, ch_req} !== 2'b00) begin
      bad++;
      $display("FAIL reset_chan_req: got %b want 00", {ch_sel, ch_req});
    end
    total++;
    if ({ch_saddr, ch_daddr, ch_len, ch_tag} !== 84'h0) begin
      bad++;
      $display("FAIL reset_chan_fields: got %h want 0", {ch_saddr, ch_daddr, ch_len, ch_tag});
    end
    total++;
    if (sched_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_sched_busy: got %b want 0", sched_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NREQ; i++) begin
      d_s[i] = $urandom; d_d[i] = $urandom; d_l[i] = 16'd8; d_t[i] = 4'(i);
    end
    start_batch(4'b1111);
    finish_batch(4'b1111, "rr1");
    total++;
    if (!(ack_q.size() == 4 && ack_q[0] == 0 && ack_q[1] == 1 && ack_q[2] == 2 && ack_q[3] == 3)) begin
      bad++;
      $display("FAIL rr_first_round: got %0d acks, first %0d want 0,1,2,3", ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1);
    end
    start_batch(4'b1111);
    finish_batch(4'b1111, "rr2");
    total++;
    if (!(ack_q.size() == 4 && ack_q[0] == 0)) begin
      bad++;
      $display("FAIL rr_wrap_to_0: got first %0d want 0", (ack_q.size() > 0) ? ack_q[0] : -1);
    end
  endtask

  task automatic test_single();
    d_s[0] = 32'h0; d_d[0] = 32'h2000; d_l[0] = 16'd64; d_t[0] = 4'h5;
    start_batch(4'b0001);
    finish_batch(4'b0001, "single");
    total++;
    if (!(ack_c.size() == 1 && ack_c[0] - t_start == 2)) begin
      bad++;
      $display("FAIL single_ack_latency: got %0d want 2", (ack_c.size() > 0) ? ack_c[0] - t_start : -1);
    end
    total++;
    if (!(frag_q.size() == 1 && frag_q[0] === {32'h0, 32'h2000, 16'd64, 4'h5})) begin
      bad++;
      $display("FAIL single_frag: got %0d frags want 1 of len 64 at 0x2000", frag_q.size());
    end
    total++;
    if (!(done_c.size() == 1 && done_c[0] == fall_c)) begin
      bad++;
      $display("FAIL single_done_timing: got %0d want %0d", (done_c.size() > 0) ? done_c[0] : -1, fall_c);
    end
  endtask

  task automatic test_split();
    d_s[1] = 32'h500; d_d[1] = 32'h1010; d_l[1] = 16'd300; d_t[1] = 4'hA;
    start_batch(4'b0010);
    finish_batch(4'b0010, "split");
    total++;
    if (!(frag_q.size() == 3 && frag_q[0] === {32'h500, 32'h1010, 16'd112, 4'hA}
          && frag_q[1] === {32'h570, 32'h1080, 16'd128, 4'hA}
          && frag_q[2] === {32'h5F0, 32'h1100, 16'd60, 4'hA})) begin
      bad++;
      $display("FAIL split_fixed_frags: got %0d frags want 112/128/60", frag_q.size());
    end
  endtask

  task automatic test_zero_len();
    d_s[2] = $urandom; d_d[2] = $urandom; d_l[2] = 16'd0; d_t[2] = 4'h3;
    start_batch(4'b0100);
    finish_batch(4'b0100, "zero");
    total++;
    if (!(ack_c.size() == 1 && done_c.size() == 1 && done_c[0] - ack_c[0] == 1)) begin
      bad++;
      $display("FAIL zero_done_gap: got acks=%0d dones=%0d want gap 1", ack_c.size(), done_c.size());
    end
  endtask

  task automatic test_stall();
    d_s[3] = 32'h9000; d_d[3] = 32'h40; d_l[3] = 16'd200; d_t[3] = 4'h7;
    force_busy = 1'b1;
    start_batch(4'b1000);
    repeat (20) @(posedge clk);
    #2;
    total++;
    if (frag_q.size() != 0 || ch_req !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_req: got %0d frags req=%b want 0", frag_q.size(), ch_req);
    end
    total++;
    if (sched_busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_sched_busy: got %b want 1", sched_busy);
    end
    force_busy = 1'b0;
    finish_batch(4'b1000, "stall");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    for (int b = 0; b < 8; b++) begin
      mask = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        d_s[i] = $urandom;
        d_d[i] = ($urandom_range(0, 3) == 0) ? 32'(32'hFFFF_FF00 + $urandom_range(0, 255)) : $urandom;
        d_l[i] = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 600));
        d_t[i] = 4'($urandom);
      end
      start_batch(mask);
      finish_batch(mask, "random");
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    d_s[1] = 32'h100; d_d[1] = 32'h200; d_l[1] = 16'd8; d_t[1] = 4'h1;
    start_batch(4'b0010);
    finish_batch(4'b0010, "pre_mid");
    d_s[2] = 32'h500; d_d[2] = 32'h1010; d_l[2] = 16'd300; d_t[2] = 4'h2;
    start_batch(4'b0100);
    reached = 1'b0;
    for (int w = 0; w < 3000 && !reached; w++) begin
      @(posedge clk);
      #2;
      reached = (frag_q.size() >= 2 && chan_busy === 1'b1);
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL mid_reach_second_frag: got %0d frags want 2 with engine busy", frag_q.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    pend = '0;
    #1;
    total++;
    if ({req_ack, req_done, ch_sel, ch_req, ch_saddr, ch_daddr, ch_len, ch_tag, sched_busy} !== '0) begin
      bad++;
      $display("FAIL mid_async_clear: got nonzero outputs want all 0");
    end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (done_q.size() != 0) begin
      bad++;
      $display("FAIL mid_no_done: got %0d dones want 0", done_q.size());
    end
    ptr_model = 0;
    for (int w = 0; w < 50 && eng_busy; w++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      d_s[i] = $urandom; d_d[i] = $urandom; d_l[i] = 16'd8; d_t[i] = 4'(i + 8);
    end
    start_batch(4'b1111);
    finish_batch(4'b1111, "post_reset");
    total++;
    if (!(ack_q.size() > 0 && ack_q[0] == 0)) begin
      bad++;
      $display("FAIL post_reset_first: got %0d want 0", (ack_q.size() > 0) ? ack_q[0] : -1);
    end
  endtask

  task automatic test_invariants();
    total++;
    if (sel_err != 0) begin
      bad++;
      $display("FAIL inv_sel_eq_req: got %0d mismatched cycles want 0", sel_err);
    end
    total++;
    if (pulse_err != 0) begin
      bad++;
      $display("FAIL inv_req_single_pulse: got %0d long pulses want 0", pulse_err);
    end
    total++;
    if (both_err != 0) begin
      bad++;
      $display("FAIL inv_ack_done_overlap: got %0d want 0", both_err);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_split();
    test_zero_len();
    test_stall();
    test_random();
    test_reset_mid();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
